// File: rtl/ahb_sub_mem.sv
// AHB-Lite subordinate backed by a word-organised SRAM, with programmable wait states
// and a two-cycle ERROR response for out-of-range, oversize or misaligned transfers.
module ahb_sub_mem #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        AFT_CLK,
    input  logic        TRST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          pend_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic [AW-1:0] idx_q;
    logic          hready_q;
    logic          hresp_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic       accept;
    logic       in_range;
    logic       bad_size;
    logic       misaligned;
    logic       xfer_err;
    logic       commit;
    logic [3:0] be;
    logic       unused_htrans;

    assign unused_htrans = HTRANS[0];

    // A new address phase may overlap the completion cycle or the second ERROR cycle.
    assign accept     = HSEL && HTRANS[1] && HREADY && (state_q == StIdle || state_q == StErr2);
    assign in_range   = (HADDR[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign bad_size   = HSIZE[2] || (HSIZE[1:0] == 2'b11);
    assign misaligned = ((HSIZE[1:0] == 2'b01) && HADDR[0]) ||
                        ((HSIZE[1:0] == 2'b10) && (HADDR[1:0] != 2'b00));
    assign xfer_err   = !in_range || bad_size || misaligned;

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be = 4'b0001 << off_q;
            2'd1:    be = off_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign commit = pend_q && write_q && !TRST;

    always_ff @(posedge AFT_CLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge AFT_CLK) begin
        if (TRST) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            pend_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= 2'd0;
            idx_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            unique case (state_q)
                StIdle, StErr2: begin
                    if (accept) begin
                        write_q <= HWRITE;
                        size_q  <= HSIZE[1:0];
                        off_q   <= HADDR[1:0];
                        idx_q   <= HADDR[AW+1:2];
                        if (xfer_err) begin
                            state_q  <= StErr1;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state_q  <= StIdle;
                            pend_q   <= 1'b1;
                            hready_q <= 1'b1;
                            hresp_q  <= 1'b0;
                        end else begin
                            state_q  <= StWait;
                            cnt_q    <= 4'(WAIT_STATES - 1);
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b0;
                        end
                    end else begin
                        state_q  <= StIdle;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= StIdle;
                        pend_q   <= 1'b1;
                        hready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StErr1: begin
                    state_q  <= StErr2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    state_q  <= StIdle;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;
    // Read data is only driven in a read completion cycle.
    assign HRDATA    = (pend_q && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_sub_mem.sv
// Directed bench for ahb_sub_mem: one instance with one wait state and one with none,
// sharing the bus, with expected data-phase responses queued as transfers are issued.
module tb_ahb_sub_mem;

    logic        clk = 1'b0;
    logic        trst;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        stall;
    logic        hready_bus;
    logic        hro0, hro1, hrsp0, hrsp1;
    logic [31:0] hrd0, hrd1;

    always #5 clk = ~clk;

    // Idle subordinate answers OKAY/ready/zero, so the bus response is a simple AND/OR.
    assign hready_bus = stall ? 1'b0 : (hro0 & hro1);

    ahb_sub_mem #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
        .AFT_CLK(clk), .TRST(trst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(hro1), .HRESP(hrsp1), .HRDATA(hrd1)
    );

    ahb_sub_mem #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .AFT_CLK(clk), .TRST(trst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(hro0), .HRESP(hrsp0), .HRDATA(hrd0)
    );

    typedef struct packed {
        int          id;
        logic        write;
        logic        err;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   xfer_id  = 0;
    bit   in_dp    = 0;
    int   dp_cyc   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        exp_t        e;
        logic        exp_rdy, exp_rsp, done, acc, rst_now;
        logic [31:0] exp_rd;
        string       nm;
        @(negedge clk);
        done = 1'b0;
        e = '0;
        if (in_dp) begin
            e       = sb_q[0];
            exp_rdy = (dp_cyc == e.waits);
            exp_rsp = e.err;
            exp_rd  = (exp_rdy && !e.err && !e.write) ? e.rdata : 32'h0;
            done    = exp_rdy;
            nm      = $sformatf("x%0d_c%0d", e.id, dp_cyc);
        end else begin
            exp_rdy = 1'b1;
            exp_rsp = 1'b0;
            exp_rd  = 32'h0;
            nm      = "idle";
        end
        chk({nm, "_hreadyout"}, {31'h0, hro0 & hro1}, {31'h0, exp_rdy});
        chk({nm, "_hresp"}, {31'h0, hrsp0 | hrsp1}, {31'h0, exp_rsp});
        chk({nm, "_hrdata"}, hrd0 | hrd1, exp_rd);
        acc     = (hsel0 | hsel1) && htrans[1] && hready_bus;
        rst_now = trst;
        @(posedge clk);
        #1;
        if (rst_now) begin
            sb_q.delete();
            in_dp  = 0;
            dp_cyc = 0;
        end else begin
            if (in_dp && (done || acc)) begin
                sb_q.delete(0);
                in_dp  = 0;
                dp_cyc = 0;
            end else if (in_dp) begin
                dp_cyc++;
            end
            if (acc && sb_q.size() > 0) begin
                in_dp  = 1;
                dp_cyc = 0;
            end
        end
        // Write data is valid only in the completion cycle; garbage elsewhere.
        if (in_dp && sb_q[0].write && dp_cyc == sb_q[0].waits) hwdata = sb_q[0].wdata;
        else hwdata = 32'hBAD0_BAD0;
    endtask

    task automatic present(input bit d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, input bit err, input logic [31:0] rd);
        exp_t e;
        hsel0  = (d == 1'b0);
        hsel1  = (d == 1'b1);
        haddr  = a;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        e.id    = xfer_id;
        e.write = wr;
        e.err   = err;
        e.waits = err ? 1 : (d ? 1 : 0);
        e.rdata = wr ? 32'h0 : rd;
        e.wdata = wd;
        xfer_id++;
        sb_q.push_back(e);
    endtask

    task automatic idle_bus();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
        if (sb_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", sb_q.size());
            sb_q.delete();
            in_dp = 0;
        end
    endtask

    task automatic single(input bit d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input bit err, input logic [31:0] rd);
        present(d, wr, a, sz, wd, err, rd);
        step();
        idle_bus();
        drain();
    endtask

    initial begin
        trst   = 1'b1;
        stall  = 1'b0;
        hwdata = 32'hBAD0_BAD0;
        idle_bus();
        @(posedge clk);
        #1;
        step();
        step();
        trst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // One wait state: word write then read.
        single(1, 1, 32'h10, 3'd2, 32'hDEAD_BEEF, 0, 32'h0);
        single(1, 0, 32'h10, 3'd2, 32'h0, 0, 32'hDEAD_BEEF);

        // Byte and half lane merges.
        single(1, 1, 32'h10, 3'd2, 32'h1122_3344, 0, 32'h0);
        single(1, 1, 32'h13, 3'd0, 32'hA500_0000, 0, 32'h0);
        single(1, 0, 32'h10, 3'd2, 32'h0, 0, 32'hA522_3344);
        single(1, 1, 32'h10, 3'd1, 32'h0000_5566, 0, 32'h0);
        single(1, 0, 32'h10, 3'd2, 32'h0, 0, 32'hA522_5566);

        // Error responses; memory must be untouched.
        single(1, 0, 32'h400, 3'd2, 32'h0, 1, 32'h0);
        single(1, 0, 32'h2, 3'd2, 32'h0, 1, 32'h0);
        single(1, 1, 32'h11, 3'd1, 32'hFFFF_FFFF, 1, 32'h0);
        single(1, 1, 32'h10, 3'd3, 32'hFFFF_FFFF, 1, 32'h0);
        single(1, 0, 32'h10, 3'd2, 32'h0, 0, 32'hA522_5566);

        // NONSEQ under an external stall must be ignored.
        hsel1  = 1'b1;
        haddr  = 32'h10;
        htrans = 2'b10;
        hsize  = 3'd2;
        stall  = 1'b1;
        step();
        stall = 1'b0;
        idle_bus();
        step();
        step();

        // Zero wait states: back-to-back write then read of the same word.
        present(0, 1, 32'h0, 3'd2, 32'hCAFE_F00D, 0, 32'h0);
        step();
        present(0, 0, 32'h0, 3'd2, 32'h0, 0, 32'hCAFE_F00D);
        step();
        idle_bus();
        drain();

        // Write aborted by reset in its completion cycle; a concurrent accept is also dropped.
        present(0, 1, 32'h0, 3'd2, 32'h1234_5678, 0, 32'h0);
        step();
        trst = 1'b1;
        present(0, 0, 32'h0, 3'd2, 32'h0, 0, 32'h0);
        step();
        trst = 1'b0;
        idle_bus();
        step();
        single(0, 0, 32'h0, 3'd2, 32'h0, 0, 32'hCAFE_F00D);

        // Error with zero wait states, then a read accepted during the second error cycle.
        present(0, 0, 32'h400, 3'd2, 32'h0, 1, 32'h0);
        step();
        idle_bus();
        step();
        present(0, 0, 32'h0, 3'd2, 32'h0, 0, 32'hCAFE_F00D);
        step();
        idle_bus();
        drain();

        // Array survives reset; one-wait-state word still readable.
        single(1, 0, 32'h10, 3'd2, 32'h0, 0, 32'hA522_5566);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
